rot_quad_filter: RTL

Upstream input stage for the grid-walk datapath. It conditions the raw rotary-encoder pins ROT_A/ROT_B with a 2-FF synchroniser and a per-line debounce filter. A quadrature FSM then validates full detent cycles and emits a one-cycle rotation_event with a rotation_direction qualifier, directly consumable by grid. It also keeps a wrapping detent position count and flags illegal quadrature jumps.

---
 rtl/rot_quad_filter_pkg.sv | 26 ++
 rtl/rot_quad_filter_debounce_bit.sv | 47 ++++
 rtl/rot_quad_filter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/rot_quad_filter_pkg.sv
// Shared constants for the rotary-encoder input stage.
//   - FSM state encoding for the quadrature detent tracker
//   - quadrature codes q = {filt_a, filt_b}
//   - rotation direction encoding
package rot_quad_filter_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,  // resting at 00
    S_CW1  = 3'd1,  // 10
    S_CW2  = 3'd2,  // 11
    S_CW3  = 3'd3,  // 01
    S_CCW1 = 3'd4,  // 01
    S_CCW2 = 3'd5,  // 11
    S_CCW3 = 3'd6,  // 10
    S_ERR  = 3'd7   // wait for rest after an illegal jump
  } quad_state_t;

  localparam logic [1:0] Q_REST = 2'b00;
  localparam logic [1:0] Q_A    = 2'b10;
  localparam logic [1:0] Q_AB   = 2'b11;
  localparam logic [1:0] Q_B    = 2'b01;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

endpackage

// File: rtl/rot_quad_filter_debounce_bit.sv
// Single-line conditioner: 2-FF synchroniser followed by a counter-based
// debounce filter.
//   clk, reset : system clock, synchronous active-high reset
//   raw        : asynchronous, bouncy input pin
//   filt       : debounced level; updates only after the synchronised line
//                has disagreed with it for DEBOUNCE_CYCLES consecutive cycles
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_reg;
  logic             s2_reg;
  logic             filt_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_reg   <= 1'b0;
      s2_reg   <= 1'b0;
      filt_reg <= 1'b0;
      cnt_reg  <= '0;
    end else begin
      s1_reg <= raw;
      s2_reg <= s1_reg;
      // Any cycle of agreement restarts the count, so short glitches vanish.
      if (s2_reg == filt_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        filt_reg <= s2_reg;
        cnt_reg  <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign filt = filt_reg;

endmodule

// File: rtl/rot_quad_filter.sv
// Rotary-encoder front end: debounces ROT_A/ROT_B, tracks full quadrature
// detent cycles and keeps a wrapping detent position.
//   clk, reset          : system clock, synchronous active-high reset
//   ROT_A, ROT_B        : raw encoder channels (asynchronous, bouncy)
//   rotation_event      : one-cycle pulse per completed detent
//   rotation_direction  : 1 = CW, 0 = CCW; updated with each event, held otherwise
//   position            : detent count, +1 CW / -1 CCW, wraps modulo 2^POS_W
//   quad_error          : one-cycle pulse when both filtered bits change together
module rot_quad_filter
  import rot_quad_filter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int POS_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ROT_A,
  input  logic             ROT_B,
  output logic             rotation_event,
  output logic             rotation_direction,
  output logic [POS_W-1:0] position,
  output logic             quad_error
);

  logic [1:0]       raw_vec;
  logic [1:0]       q;
  quad_state_t      state_reg;
  logic [1:0]       q_prev_reg;
  logic             event_reg;
  logic             dir_reg;
  logic [POS_W-1:0] pos_reg;
  logic             err_reg;

  assign raw_vec = {ROT_A, ROT_B};

  // One filter per channel; bit 1 = A, bit 0 = B.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
      debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk  (clk),
        .reset(reset),
        .raw  (raw_vec[gi]),
        .filt (q[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      q_prev_reg <= Q_REST;
      event_reg  <= 1'b0;
      dir_reg    <= DIR_CCW;
      pos_reg    <= '0;
      err_reg    <= 1'b0;
    end else begin
      event_reg  <= 1'b0;
      err_reg    <= 1'b0;
      q_prev_reg <= q;
      if (q != q_prev_reg) begin
        // A double-bit jump means a lost intermediate code: abandon the detent.
        if ((q ^ q_prev_reg) == 2'b11) begin
          state_reg <= S_ERR;
          err_reg   <= 1'b1;
        end else begin
          // Only single-bit steps reach here, and the state always mirrors
          // q_prev outside S_ERR, so each state has exactly two reachable codes.
          case (state_reg)
            S_IDLE: begin
              if (q == Q_A)      state_reg <= S_CW1;
              else if (q == Q_B) state_reg <= S_CCW1;
            end
            S_CW1: begin
              if (q == Q_AB)        state_reg <= S_CW2;
              else if (q == Q_REST) state_reg <= S_IDLE;
            end
            S_CW2: begin
              if (q == Q_B)      state_reg <= S_CW3;
              else if (q == Q_A) state_reg <= S_CW1;
            end
            S_CW3: begin
              if (q == Q_REST) begin
                state_reg <= S_IDLE;
                event_reg <= 1'b1;
                dir_reg   <= DIR_CW;
                pos_reg   <= pos_reg + POS_W'(1);
              end else if (q == Q_AB) begin
                state_reg <= S_CW2;
              end
            end
            S_CCW1: begin
              if (q == Q_AB)        state_reg <= S_CCW2;
              else if (q == Q_REST) state_reg <= S_IDLE;
            end
            S_CCW2: begin
              if (q == Q_A)      state_reg <= S_CCW3;
              else if (q == Q_B) state_reg <= S_CCW1;
            end
            S_CCW3: begin
              if (q == Q_REST) begin
                state_reg <= S_IDLE;
                event_reg <= 1'b1;
                dir_reg   <= DIR_CCW;
                pos_reg   <= pos_reg - POS_W'(1);
              end else if (q == Q_AB) begin
                state_reg <= S_CCW2;
              end
            end
            S_ERR: begin
              if (q == Q_REST) state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign rotation_event     = event_reg;
  assign rotation_direction = dir_reg;
  assign position           = pos_reg;
  assign quad_error         = err_reg;

endmodule
